// File: rtl/data_compare4.sv
// 4-bit unsigned magnitude comparator slice with cascade input and a registered
// {gt, lt, eq} result; chain slices by feeding oData of the lower slice into iData.
module data_compare4 (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [3:0] iData_a,
  input  logic [3:0] iData_b,
  input  logic [2:0] iData,
  output logic [2:0] oData
);

  // Scanning LSB to MSB lets the highest differing bit overwrite lower ones,
  // so the most significant difference wins; equal operands keep the cascade
  // code untouched, including non-one-hot codes.
  function automatic logic [2:0] compare_nibble(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] casc
  );
    logic [2:0] res;
    res = casc;
    for (int i = 0; i < 4; i++) begin
      if (a[i] != b[i]) res = a[i] ? 3'b100 : 3'b010;
    end
    return res;
  endfunction

  logic [2:0] nxt_p0;
  logic [2:0] res_p1;

  always_comb begin
    nxt_p0 = compare_nibble(iData_a, iData_b, iData);
  end

  // p0 -> p1: output register; reset clears it to the "no result" code
  always_ff @(posedge iClk) begin
    if (iRst) res_p1 <= 3'b000;
    else      res_p1 <= nxt_p0;
  end

  assign oData = res_p1;

endmodule

// File: tb/tb_data_compare4.sv
// Self-checking bench for data_compare4: directed vectors from the test plan
// followed by randomized traffic checked against an arithmetic reference model.
module tb_data_compare4;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] casc;
  logic [2:0] result;

  int compared;
  int mismatched;

  data_compare4 dut (
    .iClk   (clk),
    .iRst   (rst),
    .iData_a(a),
    .iData_b(b),
    .iData  (casc),
    .oData  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain unsigned comparison, cascade only on equality.
  function automatic logic [2:0] model(input int unsigned ma, input int unsigned mb,
                                       input logic [2:0] mc);
    if (ma > mb)      return 3'b100;
    else if (ma < mb) return 3'b010;
    else              return mc;
  endfunction

  task automatic check(input string tag, input logic [2:0] observed,
                       input logic [2:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Apply inputs away from the edge, clock once, then check the registered result.
  task automatic step(input string tag, input logic r, input logic [3:0] va,
                      input logic [3:0] vb, input logic [2:0] vc);
    logic [2:0] exp;
    @(negedge clk);
    rst  = r;
    a    = va;
    b    = vb;
    casc = vc;
    exp  = r ? 3'b000 : model(va, vb, vc);
    @(posedge clk);
    #1;
    check(tag, result, exp);
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] rc;
    logic       rr;
    logic [2:0] held;
    compared   = 0;
    mismatched = 0;
    rst  = 1'b1;
    a    = 4'h0;
    b    = 4'h0;
    casc = 3'b000;

    // Reset held for two edges with arbitrary inputs
    step("reset_edge1", 1'b1, 4'h5, 4'h3, 3'b111);
    step("reset_edge2", 1'b1, 4'hC, 4'hC, 3'b100);
    step("release_eq", 1'b0, 4'b0111, 4'b0111, 3'b001);

    // MSB decides, unsigned
    step("msb_gt", 1'b0, 4'b1000, 4'b0111, 3'b001);
    step("msb_lt", 1'b0, 4'b0111, 4'b1000, 3'b001);

    // Lower-bit decisions, back to back
    step("bit0_gt_a", 1'b0, 4'b0111, 4'b0110, 3'b001);
    step("bit1_gt",   1'b0, 4'b0011, 4'b0001, 3'b001);
    step("bit0_gt_b", 1'b0, 4'b0001, 4'b0000, 3'b001);
    step("bit0_lt",   1'b0, 4'b0000, 4'b0001, 3'b001);
    step("bit1_lt",   1'b0, 4'b0001, 4'b0011, 3'b001);

    // Equality passes the cascade through unchanged
    step("casc_001", 1'b0, 4'hA, 4'hA, 3'b001);
    step("casc_100", 1'b0, 4'hA, 4'hA, 3'b100);
    step("casc_010", 1'b0, 4'hA, 4'hA, 3'b010);
    step("casc_111", 1'b0, 4'hA, 4'hA, 3'b111);
    step("casc_000", 1'b0, 4'h3, 4'h3, 3'b000);
    step("casc_011", 1'b0, 4'hF, 4'hF, 3'b011);
    step("casc_ignored", 1'b0, 4'hA, 4'h9, 3'b010);
    step("casc_ignored_lt", 1'b0, 4'h0, 4'hF, 3'b100);

    // Reset mid-stream: asserted between edges, oData holds until the edge
    step("pre_mid_reset", 1'b0, 4'hA, 4'h9, 3'b001);
    held = 3'b100;
    @(negedge clk);
    rst  = 1'b1;
    a    = 4'h1;
    b    = 4'hE;
    casc = 3'b001;
    #1;
    check("reset_sync_hold", result, held);
    @(posedge clk);
    #1;
    check("mid_reset", result, 3'b000);
    step("resume_lt", 1'b0, 4'h1, 4'hE, 3'b001);
    step("resume_eq", 1'b0, 4'h6, 4'h6, 3'b110);

    // Randomized traffic, including equal operands, odd cascade codes and resets
    for (int i = 0; i < 300; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      rc = 3'($urandom_range(0, 7));
      rr = ($urandom_range(0, 19) == 0);
      step("random", rr, ra, rb, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
